p_bool_neuron_acc: RTL and testbench
====================================

# p_bool_neuron_acc

Sequential neuron accumulator that sits directly downstream of the boolean popcount accumulator. A fan-in wider than one popcount stage is streamed as NCHUNK signed partial sums. This block accumulates them, adds an optional bias, and emits the neuron pre-activation sum plus its sign-activated binary output. Both sides use valid/ready handshakes, so the block can be placed between a time-multiplexed popcount stage and the next layer's input buffer.

## Interface
- IN, 8: popcount fan-in per chunk; only used to derive PREC-consistent widths.
- NCHUNK, 4: partial sums per neuron, must be ≥1.
- CONF, `DEF_DCONF: datapath configuration (dconf_t).
- PREC, CONF.prec: partial-sum width.
- ACCW (localparam), PREC + $clog2(NCHUNK) + 1: accumulator/result width.
- CNTW (localparam), max($clog2(NCHUNK),1): chunk counter width.

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous, active-low reset.
- in_valid  in  1  partial sum valid.
- in_ready  out  1  block can accept a partial sum.
- in_psum  in  PREC  signed partial sum (two's complement).
- bias  in  ACCW  signed bias; present only with PERCEPTRON_BIAS_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACCW  signed accumulated sum (+bias).
- out_bit  out  1  sign activation: 1 if out_sum ≥ 0.

## Operation
- States: ACC (collecting beats) and OUT (holding result). Reset enters ACC with cnt=0 and acc=0.
- In ACC, in_ready=1. A beat is accepted when in_valid && in_ready.
  - On an accepted beat with cnt==0: acc ← sext(in_psum) + bias, or + 0 when the bias feature is absent.
  - On an accepted beat with cnt>0: acc ← acc + sext(in_psum).
  - cnt increments per accepted beat. The beat with cnt==NCHUNK-1 resets cnt to 0 and moves the FSM to OUT.
- In OUT, in_ready=0, out_valid=1, out_sum=acc, out_bit=~acc[ACCW-1]. On out_valid && out_ready, return to ACC. acc is left stale, because the next first beat overwrites it.
- out_bit is forced to 0 whenever out_valid=0.
- Arithmetic: sign-extend in_psum to ACCW before adding. The sum of partial sums cannot overflow by construction. Adding bias wraps modulo 2^ACCW; no saturation.
- NCHUNK=1: every accepted beat goes directly to OUT.
- in_valid deasserted mid-neuron: hold acc and cnt indefinitely. No timeout.
- Reset asserted mid-operation discards the partial neuron: cnt=0, acc=0, state=ACC.
- bias is sampled only on the first beat (cnt==0). Changes to bias on later beats have no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_bit=0.
- Latency: last beat accepted at edge t → out_valid=1 after edge t (visible in cycle t+1).
- Throughput: one neuron per NCHUNK+1 cycles with out_ready held high. There is one bubble cycle in OUT; in_ready=0 during OUT, with no bypass.
- All outputs are driven from registers or the state register. There is no combinational path from in_valid or out_ready to any output.
- out_sum and out_bit are stable while out_valid=1 && out_ready=0.

## Configuration
- PERCEPTRON_BIAS_EN defined: the bias port exists and is added on the first beat.
- PERCEPTRON_BIAS_EN undefined: the bias port is removed and the first beat loads sext(in_psum). All other behaviour is identical.

## Structure
- The perceptron package header (perceptron.svh) gains a shared FSM state typedef (P_NACC_ACC, P_NACC_OUT). dconf_t and `DEF_DCONF stay there.
- ACCW and CNTW are module-local localparams.
- No sub-module is needed; the block is a single flat module. It is intended to be instantiated alongside p_bool_acc in a neuron wrapper.

## Test plan
- PREC=8, NCHUNK=4, bias=0; psums 3,-2,5,-1 back-to-back, out_ready=1 → out_valid one cycle after the 4th beat, out_sum=5, out_bit=1, then in_ready=1 next cycle.
- With bias enabled: bias=-10, psums 3,-2,5,-1 → out_sum=-5, out_bit=0. Change bias to 100 on beat 2 → result still -5.
- Backpressure: hold out_ready=0 for 5 cycles after completion → in_ready=0, out_sum stable throughout; single accept on release.
- Gaps: in_valid toggled 1,0,0,1,0,1,1 carrying psums -8,-8,-8,-8 → out_sum=-32, out_bit=0, after exactly 4 accepts.
- NCHUNK=1: psum 0 → out_sum=0, out_bit=1; next psum accepted only after output handshake.
- Reset pulse after 2 of 4 beats (psums 7,7), then psums 1,1,1,1 → out_sum=4; no outputs asserted during reset; reset values checked.

Source files
------------

// File: rtl/p_bool_neuron_acc_pkg.sv
// Shared types for the boolean neuron accumulator: datapath configuration,
// the default configuration and the accumulator FSM state encoding.
package p_bool_neuron_acc_pkg;

  // Datapath configuration carried down from the popcount stage.
  typedef struct packed {
    int unsigned prec;
  } dconf_t;

  localparam dconf_t DEF_DCONF_P = '{prec: 32'd8};

  typedef enum logic {
    P_NACC_ACC = 1'b0,
    P_NACC_OUT = 1'b1
  } p_nacc_state_t;

  // Counter width that stays at least one bit when only one value is needed.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p_bool_neuron_acc.sv
// Neuron accumulator: sums NCHUNK signed partial sums (plus bias when built
// with PERCEPTRON_BIAS_EN) and presents the result with its sign activation.
`ifndef DEF_DCONF
`define DEF_DCONF p_bool_neuron_acc_pkg::DEF_DCONF_P
`endif

module p_bool_neuron_acc
  import p_bool_neuron_acc_pkg::*;
#(
  parameter int     IN     = 8,
  parameter int     NCHUNK = 4,
  parameter dconf_t CONF   = `DEF_DCONF,
  parameter int     PREC   = int'(CONF.prec),
  localparam int    ACCW   = PREC + $clog2(NCHUNK) + 1,
  localparam int    CNTW   = clog2_min1(NCHUNK)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PREC-1:0] in_psum,
`ifdef PERCEPTRON_BIAS_EN
  input  logic [ACCW-1:0] bias,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_sum,
  output logic            out_bit
);

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NCHUNK - 1);

  // Elaboration-time sanity checks on the configuration.
  if (NCHUNK < 1) begin : g_bad_nchunk
    $error("p_bool_neuron_acc: NCHUNK must be >= 1");
  end
  if (PREC < $clog2(IN + 1) + 1) begin : g_bad_prec
    $error("p_bool_neuron_acc: PREC too narrow for popcount fan-in IN");
  end

  p_nacc_state_t   state_reg, state_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic [ACCW-1:0] acc_reg, acc_next;
  logic [ACCW-1:0] psum_ext;
  logic [ACCW-1:0] bias_term;

  assign psum_ext = {{(ACCW - PREC){in_psum[PREC-1]}}, in_psum};

`ifdef PERCEPTRON_BIAS_EN
  assign bias_term = bias;
`else
  assign bias_term = '0;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_reg <= P_NACC_ACC;
      cnt_reg   <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    case (state_reg)
      P_NACC_ACC: begin
        if (in_valid) begin
          // First beat overwrites the stale result, so no clear is needed in OUT.
          if (cnt_reg == '0) begin
            acc_next = psum_ext + bias_term;
          end else begin
            acc_next = acc_reg + psum_ext;
          end
          if (cnt_reg == LAST_CNT) begin
            cnt_next   = '0;
            state_next = P_NACC_OUT;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      P_NACC_OUT: begin
        if (out_ready) begin
          state_next = P_NACC_ACC;
        end
      end
      default: begin
        state_next = P_NACC_ACC;
      end
    endcase
  end

  // Outputs come straight from registers; no path from in_valid/out_ready.
  assign in_ready  = (state_reg == P_NACC_ACC);
  assign out_valid = (state_reg == P_NACC_OUT);
  assign out_sum   = acc_reg;
  assign out_bit   = out_valid & ~acc_reg[ACCW-1];

endmodule

// File: tb/tb_p_bool_neuron_acc.sv
// Directed bench for p_bool_neuron_acc: NCHUNK=4 instance for the main
// sequences and an NCHUNK=1 instance for the single-beat case.
`timescale 1ns/1ps
module tb_p_bool_neuron_acc;

  localparam int ACCW_A = 8 + 2 + 1;
  localparam int ACCW_B = 8 + 0 + 1;

  logic clk = 1'b0;
  logic reset_;

  logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_bit;
  logic [7:0]        a_in_psum;
  logic [ACCW_A-1:0] a_out_sum;
  logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_bit;
  logic [7:0]        b_in_psum;
  logic [ACCW_B-1:0] b_out_sum;
`ifdef PERCEPTRON_BIAS_EN
  logic [ACCW_A-1:0] a_bias;
  logic [ACCW_B-1:0] b_bias;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  p_bool_neuron_acc #(.IN(8), .NCHUNK(4)) u_dut_a (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_psum   (a_in_psum),
`ifdef PERCEPTRON_BIAS_EN
    .bias      (a_bias),
`endif
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_sum   (a_out_sum),
    .out_bit   (a_out_bit)
  );

  p_bool_neuron_acc #(.IN(8), .NCHUNK(1)) u_dut_b (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_psum   (b_in_psum),
`ifdef PERCEPTRON_BIAS_EN
    .bias      (b_bias),
`endif
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum),
    .out_bit   (b_out_bit)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat into instance A; waits (bounded) for in_ready first.
  task automatic a_beat(input int v);
    int g;
    g = 0;
    while (!a_in_ready && g < 20) begin
      tick();
      g++;
    end
    if (g == 20) chk("a_ready_timeout", 0, 1);
    a_in_valid = 1'b1;
    a_in_psum  = 8'(v);
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic a_result(input string tag, input int sum, input int bit_exp);
    chk({tag, "_valid"}, 32'(a_out_valid), 1);
    chk({tag, "_sum"}, 32'($signed(a_out_sum)), sum);
    chk({tag, "_bit"}, 32'(a_out_bit), bit_exp);
    chk({tag, "_in_ready"}, 32'(a_in_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[7];
    int accepts;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    reset_ = 1'b0;
    a_in_valid = 1'b0; a_in_psum = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_psum = '0; b_out_ready = 1'b1;
`ifdef PERCEPTRON_BIAS_EN
    a_bias = '0;
    b_bias = '0;
`endif
    tick(); tick();
    chk("rst_in_ready", 32'(a_in_ready), 1);
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_out_sum", 32'($signed(a_out_sum)), 0);
    chk("rst_out_bit", 32'(a_out_bit), 0);
    reset_ = 1'b1;
    tick();

    // Back-to-back beats, result one cycle after the last beat.
    a_beat(3); a_beat(-2); a_beat(5); a_beat(-1);
    a_result("b2b", 5, 1);
    tick();
    chk("b2b_in_ready_after", 32'(a_in_ready), 1);
    chk("b2b_valid_after", 32'(a_out_valid), 0);
    chk("b2b_bit_after", 32'(a_out_bit), 0);

    // Zero sum is non-negative; extremes of the partial-sum range.
    a_beat(1); a_beat(-1); a_beat(0); a_beat(0);
    a_result("zero", 0, 1);
    tick();
    a_beat(-128); a_beat(-128); a_beat(-128); a_beat(-128);
    a_result("min", -512, 0);
    tick();
    a_beat(127); a_beat(127); a_beat(127); a_beat(127);
    a_result("max", 508, 1);
    tick();

    // Backpressure: result holds while out_ready is low, in_valid ignored.
    a_out_ready = 1'b0;
    a_beat(2); a_beat(2); a_beat(2); a_beat(2);
    a_in_valid = 1'b1; a_in_psum = 8'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_sum", 32'($signed(a_out_sum)), 8);
      chk("bp_hold_in_ready", 32'(a_in_ready), 0);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(a_out_valid), 0);
    chk("bp_release_in_ready", 32'(a_in_ready), 1);

    // Gapped input stream.
    accepts = 0;
    for (int i = 0; i < 7; i++) begin
      a_in_valid = pat[i][0];
      a_in_psum  = 8'hF8;
      if (a_in_valid && a_in_ready) accepts++;
      tick();
      if (i == 5) chk("gap_not_early", 32'(a_out_valid), 0);
    end
    a_in_valid = 1'b0;
    chk("gap_accepts", accepts, 4);
    a_result("gap", -32, 0);
    tick();

`ifdef PERCEPTRON_BIAS_EN
    a_bias = -11'sd10;
    a_beat(3); a_beat(-2); a_beat(5); a_beat(-1);
    a_result("bias", -5, 0);
    tick();
    a_bias = -11'sd10;
    a_beat(3);
    a_bias = 11'sd100;
    a_beat(-2); a_beat(5); a_beat(-1);
    a_result("bias_late", -5, 0);
    tick();
    a_bias = '0;
`endif

    // Reset mid-neuron discards partial accumulation.
    a_beat(7); a_beat(7);
    reset_ = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(a_in_ready), 1);
    chk("mid_rst_out_valid", 32'(a_out_valid), 0);
    chk("mid_rst_out_sum", 32'($signed(a_out_sum)), 0);
    chk("mid_rst_out_bit", 32'(a_out_bit), 0);
    tick();
    reset_ = 1'b1;
    a_beat(1); a_beat(1); a_beat(1); a_beat(1);
    a_result("post_rst", 4, 1);
    tick();

    // NCHUNK=1 instance.
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_psum = 8'd0;
    tick();
    chk("n1_valid", 32'(b_out_valid), 1);
    chk("n1_sum", 32'($signed(b_out_sum)), 0);
    chk("n1_bit", 32'(b_out_bit), 1);
    chk("n1_in_ready", 32'(b_in_ready), 0);
    b_in_psum = 8'd5;
    tick(); tick();
    chk("n1_hold_sum", 32'($signed(b_out_sum)), 0);
    b_out_ready = 1'b1;
    tick();
    chk("n1_release_valid", 32'(b_out_valid), 0);
    b_out_ready = 1'b0;
    tick();
    chk("n1_second_valid", 32'(b_out_valid), 1);
    chk("n1_second_sum", 32'($signed(b_out_sum)), 5);
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    tick();
    chk("n1_idle_valid", 32'(b_out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
